// File: rtl/mc_control_unit_if.sv
// Bundle between the multicycle control unit and the instruction/data memory handshakes and datapath selects.
// With MCCU_PERF_EN defined the bundle also carries the retired-instruction counter.
interface mc_control_unit_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                ihit;
    logic                dhit;
    logic                zero;
    logic                iREN;
    logic [1:0]          PC_src;
    logic                Ext_src;
    logic                LUI_src;
    logic [1:0]          portb_src;
    logic [1:0]          RegDst;
    logic [ALUOP_W-1:0]  ALU_op;
    logic                MemRead;
    logic                MemWrite;
    logic [1:0]          MemtoReg;
    logic                RegWrite;
    logic                PC_EN;
    logic                check_over;
    logic                halt;
    logic                timeout_err;
    logic [2:0]          state;
`ifdef MCCU_PERF_EN
    logic [31:0]         instr_count;

    modport master (
        input  opcode, funct, ihit, dhit, zero,
        output iREN, PC_src, Ext_src, LUI_src, portb_src, RegDst, ALU_op, MemRead, MemWrite,
               MemtoReg, RegWrite, PC_EN, check_over, halt, timeout_err, state, instr_count
    );
    modport slave (
        output opcode, funct, ihit, dhit, zero,
        input  iREN, PC_src, Ext_src, LUI_src, portb_src, RegDst, ALU_op, MemRead, MemWrite,
               MemtoReg, RegWrite, PC_EN, check_over, halt, timeout_err, state, instr_count
    );
`else
    modport master (
        input  opcode, funct, ihit, dhit, zero,
        output iREN, PC_src, Ext_src, LUI_src, portb_src, RegDst, ALU_op, MemRead, MemWrite,
               MemtoReg, RegWrite, PC_EN, check_over, halt, timeout_err, state
    );
    modport slave (
        output opcode, funct, ihit, dhit, zero,
        input  iREN, PC_src, Ext_src, LUI_src, portb_src, RegDst, ALU_op, MemRead, MemWrite,
               MemtoReg, RegWrite, PC_EN, check_over, halt, timeout_err, state
    );
`endif
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a wait watchdog and sticky halt.
// Optional MCCU_PERF_EN adds a 32-bit retired-instruction counter (instr_count).
//
// state  | meaning
// FETCH  | iREN asserted, waiting for ihit, latches opcode/funct
// DECODE | one idle cycle, selects become valid
// EXEC   | ALU selects valid; branches/jumps/NOPs retire here
// MEM    | MemRead/MemWrite until dhit; SW retires here
// WB     | register write and PC update
// HALT   | terminal, only reset leaves
module mc_control_unit #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned FUNCT_W     = 6,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input logic               CLK,
    input logic               nRST,
    mc_control_unit_if.master bus
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
    typedef enum logic [2:0] {C_NOP, C_ALU, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_LW} cls_base_t;
    typedef enum logic [3:0] {K_NOP, K_ALU, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_LW, K_SW} cls_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'('h03);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'('h05);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'('h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'('h2B);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'('h3F);
    localparam logic [CNT_W-1:0]    WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t               cur, nxt;
    cls_t                 cls;
    logic [OPCODE_W-1:0]  op_q;
    logic [FUNCT_W-1:0]   fn_q;
    logic [CNT_W-1:0]     wd_cnt;
    logic                 tout_q, tout_set, wd_hit;
    logic [ALUOP_W-1:0]   d_alu, alu_op;
    logic [1:0]           d_pb, d_pc, d_regdst, d_m2r;
    logic                 d_ext, d_lui, d_ovf;
    logic [1:0]           pc_src, portb_src, reg_dst, mem_to_reg;
    logic                 iren, ext_src, lui_src, mem_read, mem_write, reg_write, pc_en, check_over;

    // Instruction decode from the latched fields only, so selects stay stable after FETCH.
    always_comb begin
        cls = K_NOP; d_alu = '0; d_pb = 2'b00; d_ext = 1'b0; d_lui = 1'b0; d_ovf = 1'b0;
        d_pc = 2'b00; d_regdst = 2'b00; d_m2r = 2'b00;
        if (op_q == OP_R) begin
            cls = K_ALU;
            case (fn_q)
                FUNCT_W'('h00): begin d_alu = ALUOP_W'(0); d_pb = 2'b10; end
                FUNCT_W'('h02): begin d_alu = ALUOP_W'(1); d_pb = 2'b10; end
                FUNCT_W'('h08): begin cls = K_JR; d_pc = 2'b11; end
                FUNCT_W'('h20): begin d_alu = ALUOP_W'(2); d_ovf = 1'b1; end
                FUNCT_W'('h21): d_alu = ALUOP_W'(2);
                FUNCT_W'('h22): begin d_alu = ALUOP_W'(3); d_ovf = 1'b1; end
                FUNCT_W'('h23): d_alu = ALUOP_W'(3);
                FUNCT_W'('h24): d_alu = ALUOP_W'(4);
                FUNCT_W'('h25): d_alu = ALUOP_W'(5);
                FUNCT_W'('h26): d_alu = ALUOP_W'(6);
                FUNCT_W'('h27): d_alu = ALUOP_W'(7);
                FUNCT_W'('h2A): d_alu = ALUOP_W'(8);
                FUNCT_W'('h2B): d_alu = ALUOP_W'(9);
                default:        cls = K_NOP;
            endcase
        end else begin
            d_pb = 2'b01; d_regdst = 2'b01;
            case (op_q)
                OP_J:           begin cls = K_J; d_pc = 2'b10; end
                OP_JAL:         begin cls = K_JAL; d_pc = 2'b10; d_regdst = 2'b10; d_m2r = 2'b10; end
                OP_BEQ:         begin cls = K_BEQ; d_alu = ALUOP_W'(3); d_pb = 2'b00; d_ext = 1'b1; end
                OP_BNE:         begin cls = K_BNE; d_alu = ALUOP_W'(3); d_pb = 2'b00; d_ext = 1'b1; end
                OP_LW:          begin cls = K_LW; d_alu = ALUOP_W'(2); d_ext = 1'b1; d_m2r = 2'b01; end
                OP_SW:          begin cls = K_SW; d_alu = ALUOP_W'(2); d_ext = 1'b1; end
                OPCODE_W'('h08): begin cls = K_ALU; d_alu = ALUOP_W'(2); d_ext = 1'b1; d_ovf = 1'b1; end
                OPCODE_W'('h09): begin cls = K_ALU; d_alu = ALUOP_W'(2); d_ext = 1'b1; end
                OPCODE_W'('h0A): begin cls = K_ALU; d_alu = ALUOP_W'(8); d_ext = 1'b1; end
                OPCODE_W'('h0B): begin cls = K_ALU; d_alu = ALUOP_W'(9); d_ext = 1'b1; end
                OPCODE_W'('h0C): begin cls = K_ALU; d_alu = ALUOP_W'(4); end
                OPCODE_W'('h0D): begin cls = K_ALU; d_alu = ALUOP_W'(5); end
                OPCODE_W'('h0E): begin cls = K_ALU; d_alu = ALUOP_W'(6); end
                OPCODE_W'('h0F): begin cls = K_ALU; d_alu = ALUOP_W'(2); d_lui = 1'b1; end
                default:        begin cls = K_NOP; d_pb = 2'b00; d_regdst = 2'b00; end
            endcase
        end
    end

    assign wd_hit = (MEM_TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_comb begin
        nxt = cur; tout_set = 1'b0;
        iren = 1'b0; pc_src = 2'b00; ext_src = 1'b0; lui_src = 1'b0; portb_src = 2'b00;
        reg_dst = 2'b00; alu_op = '0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 2'b00;
        reg_write = 1'b0; pc_en = 1'b0; check_over = 1'b0;
        if (cur inside {DECODE, EXEC, MEM, WB}) begin
            pc_src = d_pc; ext_src = d_ext; lui_src = d_lui; portb_src = d_pb;
            reg_dst = d_regdst; alu_op = d_alu; mem_to_reg = d_m2r; check_over = d_ovf;
        end
        case (cur)
            FETCH: begin
                iren = 1'b1;
                if (bus.ihit) nxt = DECODE;
                else if (wd_hit) begin nxt = HALT; tout_set = 1'b1; end
            end
            DECODE: nxt = (op_q == OP_HALT) ? HALT : EXEC;
            EXEC: begin
                case (cls)
                    K_BEQ:        begin pc_src = bus.zero ? 2'b01 : 2'b00; pc_en = 1'b1; nxt = FETCH; end
                    K_BNE:        begin pc_src = bus.zero ? 2'b00 : 2'b01; pc_en = 1'b1; nxt = FETCH; end
                    K_J, K_JR:    begin pc_en = 1'b1; nxt = FETCH; end
                    K_LW, K_SW:   nxt = MEM;
                    K_ALU, K_JAL: nxt = WB;
                    default:      begin pc_src = 2'b00; pc_en = 1'b1; nxt = FETCH; end
                endcase
            end
            MEM: begin
                mem_read  = (cls == K_LW);
                mem_write = (cls == K_SW);
                if (bus.dhit) begin
                    if (cls == K_LW) nxt = WB;
                    else begin pc_en = 1'b1; nxt = FETCH; end
                end else if (wd_hit) begin
                    nxt = HALT; tout_set = 1'b1;
                end
            end
            WB: begin reg_write = 1'b1; pc_en = 1'b1; nxt = FETCH; end
            HALT: nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    // Watchdog restarts on any state change and saturates rather than wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur    <= FETCH;
            op_q   <= '0;
            fn_q   <= '0;
            wd_cnt <= '0;
            tout_q <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == FETCH && bus.ihit) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
            if (nxt != cur) wd_cnt <= '0;
            else if ((cur == FETCH || cur == MEM) && !(&wd_cnt)) wd_cnt <= wd_cnt + CNT_W'(1);
            if (tout_set) tout_q <= 1'b1;
        end
    end

`ifdef MCCU_PERF_EN
    logic [31:0] instr_cnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      instr_cnt <= '0;
        else if (pc_en) instr_cnt <= instr_cnt + 32'd1;
    end
    assign bus.instr_count = instr_cnt;
`endif

    assign bus.iREN        = iren;
    assign bus.PC_src      = pc_src;
    assign bus.Ext_src     = ext_src;
    assign bus.LUI_src     = lui_src;
    assign bus.portb_src   = portb_src;
    assign bus.RegDst      = reg_dst;
    assign bus.ALU_op      = alu_op;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.PC_EN       = pc_en;
    assign bus.check_over  = check_over;
    assign bus.halt        = (cur == HALT);
    assign bus.timeout_err = tout_q;
    assign bus.state       = cur;
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: random instruction streams against a per-instruction reference model.
module tb_mc_control_unit;
    localparam int TO = 4;

    typedef enum {K_NOP, K_ALU, K_LUI, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_LW, K_SW, K_HALT} kind_t;
    typedef struct {
        int is_halt, tout, cyc, iren_n, rd_n, wr_n, rw_n, pc_src, st, reg_dst, m2r;
        int has_exec, chk_alu, alu, pb, ext, ovf, lui, icount;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_unit_if #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4)) bus ();
    mc_control_unit #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4), .MEM_TIMEOUT(TO), .CNT_W(8))
        dut (.CLK(clk), .nRST(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: what each MIPS instruction means, straight from the opcode/funct tables.
    function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       output kind_t k, output int alu, output int pb,
                                       output int ext, output int ovf);
        k = K_NOP; alu = 0; pb = 0; ext = 0; ovf = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h00: begin k = K_ALU; alu = 0; pb = 2; end
                6'h02: begin k = K_ALU; alu = 1; pb = 2; end
                6'h08: k = K_JR;
                6'h20: begin k = K_ALU; alu = 2; ovf = 1; end
                6'h21: begin k = K_ALU; alu = 2; end
                6'h22: begin k = K_ALU; alu = 3; ovf = 1; end
                6'h23: begin k = K_ALU; alu = 3; end
                6'h24: begin k = K_ALU; alu = 4; end
                6'h25: begin k = K_ALU; alu = 5; end
                6'h26: begin k = K_ALU; alu = 6; end
                6'h27: begin k = K_ALU; alu = 7; end
                6'h2A: begin k = K_ALU; alu = 8; end
                6'h2B: begin k = K_ALU; alu = 9; end
                default: k = K_NOP;
            endcase
        end else begin
            case (op)
                6'h02: k = K_J;
                6'h03: k = K_JAL;
                6'h04: k = K_BEQ;
                6'h05: k = K_BNE;
                6'h23: begin k = K_LW; alu = 2; pb = 1; ext = 1; end
                6'h2B: begin k = K_SW; alu = 2; pb = 1; ext = 1; end
                6'h08: begin k = K_ALU; alu = 2; pb = 1; ext = 1; ovf = 1; end
                6'h09: begin k = K_ALU; alu = 2; pb = 1; ext = 1; end
                6'h0A: begin k = K_ALU; alu = 8; pb = 1; ext = 1; end
                6'h0B: begin k = K_ALU; alu = 9; pb = 1; ext = 1; end
                6'h0C: begin k = K_ALU; alu = 4; pb = 1; end
                6'h0D: begin k = K_ALU; alu = 5; pb = 1; end
                6'h0E: begin k = K_ALU; alu = 6; pb = 1; end
                6'h0F: k = K_LUI;
                6'h3F: k = K_HALT;
                default: k = K_NOP;
            endcase
        end
    endfunction

    // Expected observable outcome of one instruction given its wait cycles (w fetch, d mem) and zero flag.
    function automatic exp_t build(input logic [5:0] op, input logic [5:0] fn, input int w, input int d,
                                   input logic z, input int done);
        exp_t e;
        kind_t k;
        int alu, pb, ext, ovf;
        e = '{default: 0};
        ref_decode(op, fn, k, alu, pb, ext, ovf);
        e.icount = done;
        if (w >= TO) begin
            e.is_halt = 1; e.tout = 1; e.cyc = TO + 1; e.iren_n = TO;
            return e;
        end
        e.iren_n = w + 1;
        if (k == K_HALT) begin
            e.is_halt = 1; e.cyc = w + 3;
            return e;
        end
        e.has_exec = 1;
        e.lui = (k == K_LUI);
        e.chk_alu = (k == K_ALU || k == K_LW || k == K_SW);
        e.alu = alu; e.pb = pb; e.ext = ext; e.ovf = ovf;
        e.cyc = w + 3;
        e.st = 2;
        case (k)
            K_BEQ: e.pc_src = z ? 1 : 0;
            K_BNE: e.pc_src = z ? 0 : 1;
            K_J:   e.pc_src = 2;
            K_JR:  e.pc_src = 3;
            K_LW, K_SW: begin
                if (d >= TO) begin
                    e.is_halt = 1; e.tout = 1; e.cyc += TO + 1;
                    if (k == K_LW) e.rd_n = TO; else e.wr_n = TO;
                end else begin
                    e.cyc += d + 1;
                    if (k == K_SW) begin e.wr_n = d + 1; e.st = 3; end
                    else begin e.rd_n = d + 1; e.cyc += 1; e.st = 4; e.rw_n = 1; e.reg_dst = 1; e.m2r = 1; end
                end
            end
            K_ALU, K_LUI: begin e.cyc += 1; e.st = 4; e.rw_n = 1; e.reg_dst = (op == 6'h00) ? 0 : 1; end
            K_JAL: begin e.cyc += 1; e.st = 4; e.rw_n = 1; e.reg_dst = 2; e.m2r = 2; e.pc_src = 2; end
            default: e.pc_src = 0;
        endcase
        return e;
    endfunction

    // Monitor: counts cycles and strobes per instruction, compares when PC_EN fires or halt first appears.
    int m_cyc = 0, m_ir = 0, m_rd = 0, m_wr = 0, m_rw = 0, m_ex = 0, m_hseen = 0;
    int x_alu = 0, x_pb = 0, x_ext = 0, x_ovf = 0, x_lui = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_cyc = 0; m_ir = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_ex = 0; m_hseen = 0;
        end else begin
            m_cyc++;
            m_ir += int'(bus.iREN); m_rd += int'(bus.MemRead);
            m_wr += int'(bus.MemWrite); m_rw += int'(bus.RegWrite);
            if (bus.state == 3'd2) begin
                m_ex = 1; x_alu = int'(bus.ALU_op); x_pb = int'(bus.portb_src);
                x_ext = int'(bus.Ext_src); x_ovf = int'(bus.check_over); x_lui = int'(bus.LUI_src);
            end
            if (bus.PC_EN || (bus.halt && m_hseen == 0)) begin
                if (bus.halt) m_hseen = 1;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: PC_EN=%0d halt=%0d state=%0d with nothing expected",
                             bus.PC_EN, bus.halt, bus.state);
                end else begin
                    e = q.pop_front();
                    check("halt_event", bus.halt, e.is_halt);
                    check("cycles", m_cyc, e.cyc);
                    check("iren_cycles", m_ir, e.iren_n);
                    check("memread_cycles", m_rd, e.rd_n);
                    check("memwrite_cycles", m_wr, e.wr_n);
                    check("regwrite_cycles", m_rw, e.rw_n);
                    check("timeout_err", bus.timeout_err, e.tout);
                    if (e.is_halt == 0) begin
                        check("pc_src", bus.PC_src, e.pc_src);
                        check("retire_state", bus.state, e.st);
                    end
                    if (e.rw_n != 0) begin
                        check("reg_dst", bus.RegDst, e.reg_dst);
                        check("mem_to_reg", bus.MemtoReg, e.m2r);
                    end
                    if (e.has_exec != 0) begin
                        check("exec_seen", m_ex, 1);
                        check("lui_src", x_lui, e.lui);
                    end
                    if (e.chk_alu != 0) begin
                        check("alu_op", x_alu, e.alu);
                        check("portb_src", x_pb, e.pb);
                        check("ext_src", x_ext, e.ext);
                        check("check_over", x_ovf, e.ovf);
                    end
`ifdef MCCU_PERF_EN
                    if (e.is_halt != 0) check("instr_count", bus.instr_count, e.icount);
`endif
                end
                m_cyc = 0; m_ir = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_ex = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
        bus.ihit = 1'($urandom); bus.dhit = 1'($urandom); bus.zero = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        noise();
        step();
        check("rst_state", bus.state, 0);
        check("rst_iren", bus.iREN, 1);
        check("rst_pc_en", bus.PC_EN, 0);
        check("rst_regwrite", bus.RegWrite, 0);
        check("rst_halt", bus.halt, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_alu_op", bus.ALU_op, 0);
        check("rst_memread", bus.MemRead, 0);
        step();
        rst_n = 1'b1;
        n_done = 0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int w, input int d,
                             input logic z, output int halted);
        exp_t e;
        kind_t k;
        int alu, pb, ext, ovf;
        e = build(op, fn, w, d, z, n_done);
        q.push_back(e);
        halted = e.is_halt;
        ref_decode(op, fn, k, alu, pb, ext, ovf);
        if (w >= TO) begin
            repeat (TO + 2) begin noise(); bus.ihit = 1'b0; step(); end
            return;
        end
        repeat (w) begin noise(); bus.ihit = 1'b0; step(); end
        noise(); bus.ihit = 1'b1; bus.opcode = op; bus.funct = fn; step();
        noise(); step();
        if (k == K_HALT) begin
            repeat (2) begin noise(); step(); end
            return;
        end
        noise(); bus.zero = z; step();
        if (k == K_LW || k == K_SW) begin
            if (d >= TO) begin
                repeat (TO + 1) begin noise(); bus.dhit = 1'b0; step(); end
                return;
            end
            repeat (d) begin noise(); bus.dhit = 1'b0; step(); end
            noise(); bus.dhit = 1'b1; step();
        end
        if (k == K_LW || k == K_ALU || k == K_LUI || k == K_JAL) begin noise(); step(); end
        n_done++;
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] rfn [15];
        logic [5:0] bad [4];
        int r;
        rfn = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h01};
        bad = '{6'h01, 6'h10, 6'h3E, 6'h06};
        r = int'($urandom_range(0, 99));
        fn = 6'($urandom);
        if (r < 40)      begin op = 6'h00; fn = rfn[$urandom_range(0, 14)]; end
        else if (r < 60) op = 6'($urandom_range(8, 15));
        else if (r < 70) op = ($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B;
        else if (r < 80) op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
        else if (r < 90) op = ($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03;
        else if (r < 96) op = bad[$urandom_range(0, 3)];
        else             op = 6'h3F;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int h;
        logic [5:0] op, fn;
        int w, d;
        noise();
        do_reset();
        // Directed cases from the test plan
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, h);       // ADDU
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, h);       // LW, dhit late by 3
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, h);       // BEQ taken
        run_instr(6'h05, 6'h00, 1, 0, 1'b1, h);       // BNE not taken
        run_instr(6'h03, 6'h00, 2, 0, 1'b0, h);       // JAL
        run_instr(6'h2B, 6'h00, TO - 1, TO - 1, 1'b0, h); // hit on the timeout cycle wins
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, h);       // JR
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, h);       // HALT opcode
        repeat (3) begin noise(); bus.ihit = 1'b1; bus.dhit = 1'b1; step(); end
        check("halt_sticky", bus.halt, 1);
        check("halt_state", bus.state, 5);
        check("halt_iren", bus.iREN, 0);
        check("halt_pc_en", bus.PC_EN, 0);
        check("halt_no_timeout", bus.timeout_err, 0);
        do_reset();
        run_instr(6'h00, 6'h21, TO, 0, 1'b0, h);      // fetch timeout
        check("tout_err", bus.timeout_err, 1);
        check("tout_iren", bus.iREN, 0);
        check("tout_state", bus.state, 5);
        do_reset();
        run_instr(6'h23, 6'h00, 1, TO, 1'b0, h);      // mem timeout
        do_reset();
        // Abandon an ADDU in EXEC: no retire event may follow
        noise(); bus.ihit = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h21; step();
        noise(); step();
        rst_n = 1'b0; noise(); step(); step();
        check("abort_regwrite", bus.RegWrite, 0);
        check("abort_pc_en", bus.PC_EN, 0);
        rst_n = 1'b1; n_done = 0;
        // Random stream
        for (int i = 0; i < 250; i++) begin
            pick(op, fn);
            w = ($urandom_range(0, 29) == 0) ? TO : int'($urandom_range(0, TO - 1));
            d = ($urandom_range(0, 14) == 0) ? TO : int'($urandom_range(0, TO - 1));
            run_instr(op, fn, w, d, 1'($urandom), h);
            if (h != 0) do_reset();
        end
        repeat (3) begin noise(); bus.ihit = 1'b0; step(); end
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decode.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ihit/dhit memory handshakes.
- Latches opcode/funct internally and drives datapath selects per state.
- Adds a wait-timeout watchdog and a sticky halt; sits between the instruction register/cache interface and the datapath muxes.

Parameters:
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALUOP_W, 4, ALU_op width
- MEM_TIMEOUT, 255, max wait cycles in FETCH or MEM before error halt; 0 disables the watchdog
- CNT_W, 8, watchdog counter width; must hold MEM_TIMEOUT

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  instruction opcode, sampled in FETCH on ihit
- funct  in  FUNCT_W  instruction funct, sampled with opcode
- ihit  in  1  instruction memory ready
- dhit  in  1  data memory ready
- zero  in  1  ALU zero flag, valid in EXEC
- iREN  out  1  instruction read request
- PC_src  out  2  00 +4, 01 branch, 10 jump, 11 register
- Ext_src  out  1  1 sign extend, 0 zero extend
- LUI_src  out  1  1 for LUI
- portb_src  out  2  00 rt, 01 imm, 10 shamt
- RegDst  out  2  00 rd, 01 rt, 10 r31
- ALU_op  out  ALUOP_W  SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7 SLT=8 SLTU=9
- MemRead  out  1  data read request
- MemWrite  out  1  data write request
- MemtoReg  out  2  00 alu, 01 mem, 10 pc+4
- RegWrite  out  1  register file write enable
- PC_EN  out  1  one-cycle PC update strobe
- check_over  out  1  overflow check enable (ADD, SUB, ADDI)
- halt  out  1  sticky halt
- timeout_err  out  1  sticky watchdog error
- state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5

Behaviour:
- Reset, asynchronous on nRST low:
  - state=FETCH, latched opcode/funct=0, watchdog=0, halt=0, timeout_err=0.
  - Outputs then decode as FETCH: iREN=1, all other outputs 0.
- Outputs are combinational from state plus the latched fields. Selects hold their decoded value in every state after FETCH so the datapath stays stable.
- FETCH:
  - iREN=1.
  - On ihit: latch opcode/funct and go to DECODE.
  - Without ihit: stay in FETCH and increment the watchdog.
- DECODE: one cycle, no strobes; then EXEC, or HALT if opcode=0x3F.
- EXEC: ALU_op, portb_src, Ext_src, LUI_src and check_over are valid. Next state:
  - BEQ(0x04)/BNE(0x05): PC_src=01 when zero=1 (BEQ) or zero=0 (BNE), else 00; PC_EN=1; go to FETCH.
  - J(0x02): PC_src=10, PC_EN=1, go to FETCH.
  - R-type JR (funct 0x08): PC_src=11, PC_EN=1, go to FETCH.
  - LW(0x23)/SW(0x2B): ALU_op=ADD, portb_src=01, Ext_src=1; go to MEM.
  - JAL(0x03), R-type ALU, and I-type ALU (0x08–0x0F): go to WB.
  - Unknown opcode/funct: NOP; PC_src=00, PC_EN=1, go to FETCH.
- MEM:
  - LW asserts MemRead; SW asserts MemWrite.
  - On dhit: LW goes to WB; SW pulses PC_EN and goes to FETCH.
  - Without dhit: stay in MEM and increment the watchdog.
- WB:
  - RegWrite=1 and PC_EN=1; then FETCH.
  - RegDst: R-type 00, I-type/LW 01, JAL 10.
  - MemtoReg: LW 01, JAL 10, else 00.
  - JAL also drives PC_src=10.
- HALT: terminal. halt=1 and every strobe (iREN, MemRead, MemWrite, RegWrite, PC_EN) is 0. Only nRST exits.
- Watchdog:
  - Clears on every state change.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT while waiting, go to HALT with timeout_err=1.
  - Counter saturates and never wraps.
- Simultaneous events: ihit or dhit on the same cycle the count hits MEM_TIMEOUT counts as a hit; the hit wins.
- Reset mid-instruction: abandons the instruction; no PC_EN or RegWrite is emitted.

Optional Feature:
- Macro: MCCU_PERF_EN.
- Defined:
  - Adds output instr_count [31:0], reset to 0.
  - Increments on every PC_EN pulse and wraps at 2^32.
  - Frozen in HALT.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then ihit=1 continuously with ADDU (op 0, funct 0x21) -> state 0→1→2→4→0; RegWrite=1 and PC_EN=1 only in WB; ALU_op=2, RegDst=00.
- LW with dhit held low 3 cycles -> MemRead=1 for 4 MEM cycles; WB has MemtoReg=01, RegDst=01, PC_EN one cycle.
- BEQ with zero=1, then BNE with zero=1 -> PC_src=01 with PC_EN in EXEC, then PC_src=00 with PC_EN; RegWrite never asserted.
- JAL -> WB has RegDst=10, MemtoReg=10, PC_src=10, RegWrite=1.
- MEM_TIMEOUT=4, ihit stuck 0 -> HALT after 4 FETCH cycles, timeout_err=1, iREN=0; nRST pulse returns to state 0 with iREN=1.
- Opcode 0x3F -> HALT after DECODE, halt=1 sticky, no PC_EN; with MCCU_PERF_EN, instr_count equals the number of prior completed instructions.
